// File: rtl/alu_arbiter_pkg.sv
// rtl/alu_arbiter_pkg.sv - shared width, opcode constants and FSM state type for alu_arbiter
package alu_arbiter_pkg;

    localparam int REG_FILE_WIDTH = 32;

    localparam int OP_ADD = 0;
    localparam int OP_SUB = 1;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

endpackage

// File: rtl/alu_arbiter_if.sv
// rtl/alu_arbiter_if.sv - two-requester ALU request/response bundle
interface alu_arbiter_if
    import alu_arbiter_pkg::*;
#(
    parameter int WIDTH = REG_FILE_WIDTH,
    parameter int OPW   = 4
);
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [OPW-1:0]   req_op0;
    logic [OPW-1:0]   req_op1;
    logic [WIDTH-1:0] req_a0;
    logic [WIDTH-1:0] req_b0;
    logic [WIDTH-1:0] req_a1;
    logic [WIDTH-1:0] req_b1;
    logic [1:0]       rsp_valid;
    logic [1:0]       rsp_ready;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_zero;

    modport master (
        output req_valid, req_op0, req_op1, req_a0, req_b0, req_a1, req_b1, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_zero
    );

    modport slave (
        input  req_valid, req_op0, req_op1, req_a0, req_b0, req_a1, req_b1, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_zero
    );
endinterface

// File: rtl/alu_arbiter_alu.sv
// rtl/alu_arbiter_alu.sv - shared combinational ALU; SUB on its opcode, ADD for everything else
module alu
    import alu_arbiter_pkg::*;
#(
    parameter int WIDTH = REG_FILE_WIDTH,
    parameter int OPW   = 4
) (
    input  logic [OPW-1:0]   op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);

    always_comb begin
        if (op == OPW'(OP_SUB)) begin
            y = a - b;
        end else begin
            y = a + b;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin arbiter sharing one ALU between two requesters
// with a one-entry result register that sustains one operation per cycle.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int WIDTH = REG_FILE_WIDTH,
    parameter int OPW   = 4
) (
    input  logic  clk,
    input  logic  reset,
    alu_arbiter_if.slave bus
);

    state_t           state;
    state_t           state_nxt;
    logic             tag;
    logic             last_grant;
    logic [WIDTH-1:0] data_q;
    logic             zero_q;

    logic             can_issue;
    logic [1:0]       grant;
    logic             fire;
    logic             sel;
    logic [OPW-1:0]   alu_op;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [WIDTH-1:0] alu_y;

    // A new issue is allowed when empty, or when the held result retires this cycle.
    always_comb begin
        can_issue = (state == ST_EMPTY) || bus.rsp_ready[tag];
        grant     = 2'b00;
        if (!reset && can_issue) begin
            if (bus.req_valid == 2'b11) begin
                grant = last_grant ? 2'b01 : 2'b10;
            end else begin
                grant = bus.req_valid;
            end
        end
        fire = |grant;
        sel  = grant[1];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_EMPTY: if (fire) state_nxt = ST_FULL;
            ST_FULL:  if (!fire && bus.rsp_ready[tag]) state_nxt = ST_EMPTY;
            default:  state_nxt = ST_EMPTY;
        endcase
    end

    always_comb begin
        bus.req_ready = grant;
        bus.rsp_valid = 2'b00;
        if (state == ST_FULL) begin
            bus.rsp_valid = tag ? 2'b10 : 2'b01;
        end
        bus.rsp_data = data_q;
        bus.rsp_zero = zero_q;
    end

    always_comb begin
        alu_op = sel ? bus.req_op1 : bus.req_op0;
        alu_a  = sel ? bus.req_a1  : bus.req_a0;
        alu_b  = sel ? bus.req_b1  : bus.req_b0;
    end

    alu #(
        .WIDTH (WIDTH),
        .OPW   (OPW)
    ) u_alu (
        .op (alu_op),
        .a  (alu_a),
        .b  (alu_b),
        .y  (alu_y)
    );

    // last_grant resets to 1 so requester 0 wins the first tie.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q     <= '0;
            zero_q     <= 1'b0;
            tag        <= 1'b0;
            last_grant <= 1'b1;
        end else if (fire) begin
            data_q     <= alu_y;
            zero_q     <= (alu_y == '0);
            tag        <= sel;
            last_grant <= sel;
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed and randomized self-checking bench for alu_arbiter
module tb_alu_arbiter;
    import alu_arbiter_pkg::*;

    localparam int W   = 32;
    localparam int OPW = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    alu_arbiter_if #(.WIDTH(W), .OPW(OPW)) bus();

    alu_arbiter #(.WIDTH(W), .OPW(OPW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    // Reference: at most one outstanding result, plus who was served last.
    bit           pend_v;
    bit           pend_tag;
    logic [W-1:0] pend_data;
    bit           last_served;
    logic [1:0]   prev_grant;
    int           wait0;
    int           wait1;

    function automatic logic [W-1:0] ref_alu(input logic [OPW-1:0] op,
                                             input logic [W-1:0] a, input logic [W-1:0] b);
        longint unsigned r;
        if (op == OPW'(1)) r = {32'h0, a} + 64'h1_0000_0000 - {32'h0, b};
        else               r = {32'h0, a} + {32'h0, b};
        return r[W-1:0];
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        pend_v      = 1'b0;
        pend_tag    = 1'b0;
        pend_data   = '0;
        last_served = 1'b1;
        prev_grant  = 2'b00;
        wait0       = 0;
        wait1       = 0;
    endtask

    task automatic clear_inputs();
        bus.req_valid = 2'b00;
        bus.req_op0 = '0; bus.req_op1 = '0;
        bus.req_a0  = '0; bus.req_b0  = '0;
        bus.req_a1  = '0; bus.req_b1  = '0;
        bus.rsp_ready = 2'b00;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // One clock: check DUT mid-cycle against the reference, then advance both.
    task automatic cycle(input string tag);
        logic [1:0] v;
        logic [1:0] exp_ready;
        logic [1:0] exp_valid;
        logic [1:0] rr;
        @(negedge clk);
        v = bus.req_valid;
        if (pend_v && !bus.rsp_ready[pend_tag]) exp_ready = 2'b00;
        else if (v == 2'b11)                    exp_ready = last_served ? 2'b01 : 2'b10;
        else                                    exp_ready = v;
        exp_valid = pend_v ? (pend_tag ? 2'b10 : 2'b01) : 2'b00;
        rr = bus.req_ready;
        chk({tag, ".req_ready"}, 64'(rr), 64'(exp_ready));
        chk({tag, ".rsp_valid"}, 64'(bus.rsp_valid), 64'(exp_valid));
        if (pend_v) begin
            chk({tag, ".rsp_data"}, 64'(bus.rsp_data), 64'(pend_data));
            chk({tag, ".rsp_zero"}, 64'(bus.rsp_zero), 64'(pend_data == '0));
        end
        chk({tag, ".ready_not_11"}, 64'(rr == 2'b11), 64'(0));
        // a waiting requester may be passed over at most once while the other is served
        wait0 = (v[0] && !rr[0] && rr[1]) ? wait0 + 1 : (rr[0] || !v[0]) ? 0 : wait0;
        wait1 = (v[1] && !rr[1] && rr[0]) ? wait1 + 1 : (rr[1] || !v[1]) ? 0 : wait1;
        chk({tag, ".starve"}, 64'((wait0 > 1) || (wait1 > 1)), 64'(0));
        if (pend_v && bus.rsp_ready[pend_tag]) pend_v = 1'b0;
        if (exp_ready != 2'b00) begin
            pend_v      = 1'b1;
            pend_tag    = exp_ready[1];
            pend_data   = exp_ready[1] ? ref_alu(bus.req_op1, bus.req_a1, bus.req_b1)
                                       : ref_alu(bus.req_op0, bus.req_a0, bus.req_b0);
            last_served = exp_ready[1];
        end
        prev_grant = exp_ready;
        @(posedge clk);
        #1;
    endtask

    task automatic randomize_requester(input int i);
        logic [OPW-1:0] op;
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        int sel;
        sel = int'($urandom_range(0, 9));
        op  = (sel < 4) ? OPW'(0) : (sel < 8) ? OPW'(1) : OPW'($urandom_range(2, 15));
        a   = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 3)) : W'($urandom);
        b   = ($urandom_range(0, 3) == 0) ? a : W'($urandom);
        if (i == 0) begin
            bus.req_valid[0] = ($urandom_range(0, 3) != 0);
            bus.req_op0 = op; bus.req_a0 = a; bus.req_b0 = b;
        end else begin
            bus.req_valid[1] = ($urandom_range(0, 3) != 0);
            bus.req_op1 = op; bus.req_a1 = a; bus.req_b1 = b;
        end
    endtask

    initial begin
        int grant_tbl[4];
        int data_tbl[4];
        grant_tbl = '{1, 2, 1, 2};
        data_tbl  = '{0, 3, 0, 3};

        // reset values, checked while reset is held
        reset = 1'b1;
        clear_inputs();
        bus.req_valid = 2'b11;
        model_reset();
        #12;
        chk("rst.rsp_valid", 64'(bus.rsp_valid), 64'(0));
        chk("rst.rsp_data",  64'(bus.rsp_data),  64'(0));
        chk("rst.rsp_zero",  64'(bus.rsp_zero),  64'(0));
        chk("rst.req_ready", 64'(bus.req_ready), 64'(0));
        do_reset();

        // single ADD from requester 0
        bus.req_valid = 2'b01; bus.req_op0 = 4'd0; bus.req_a0 = 32'd5; bus.req_b0 = 32'd7;
        bus.rsp_ready = 2'b01;
        cycle("add");
        bus.req_valid = 2'b00;
        chk("add.rsp_valid", 64'(bus.rsp_valid), 64'(2'b01));
        chk("add.rsp_data",  64'(bus.rsp_data),  64'(12));
        chk("add.rsp_zero",  64'(bus.rsp_zero),  64'(0));
        cycle("add_drain");

        // continuous contention alternates grants at full throughput
        do_reset();
        bus.req_valid = 2'b11; bus.rsp_ready = 2'b11;
        bus.req_op0 = 4'd1; bus.req_a0 = 32'd9; bus.req_b0 = 32'd9;
        bus.req_op1 = 4'd0; bus.req_a1 = 32'd1; bus.req_b1 = 32'd2;
        for (int k = 0; k < 4; k++) begin
            cycle("rr");
            chk($sformatf("rr%0d.rsp_valid", k), 64'(bus.rsp_valid), 64'(grant_tbl[k]));
            chk($sformatf("rr%0d.rsp_data", k),  64'(bus.rsp_data),  64'(data_tbl[k]));
            chk($sformatf("rr%0d.rsp_zero", k),  64'(bus.rsp_zero),  64'(data_tbl[k] == 0));
        end
        bus.req_valid = 2'b00;
        cycle("rr_drain");

        // back-pressure on requester 1's result
        do_reset();
        bus.req_valid = 2'b10; bus.req_op1 = 4'd0; bus.req_a1 = 32'd1; bus.req_b1 = 32'd2;
        bus.rsp_ready = 2'b00;
        cycle("bp_issue");
        bus.req_valid = 2'b11; bus.req_op0 = 4'd0; bus.req_a0 = 32'd4; bus.req_b0 = 32'd4;
        for (int k = 0; k < 3; k++) begin
            chk("bp.req_ready", 64'(bus.req_ready), 64'(0));
            chk("bp.rsp_data",  64'(bus.rsp_data),  64'(3));
            cycle("bp_hold");
        end
        bus.rsp_ready = 2'b10;
        #1;
        chk("bp.retire_grant", 64'(bus.req_ready), 64'(2'b01));
        cycle("bp_retire");
        bus.req_valid = 2'b00; bus.rsp_ready = 2'b11;
        chk("bp.next_valid", 64'(bus.rsp_valid), 64'(2'b01));
        chk("bp.next_data",  64'(bus.rsp_data),  64'(8));
        cycle("bp_drain");

        // wrap-around SUB and unknown opcode
        do_reset();
        bus.req_valid = 2'b01; bus.req_op0 = 4'd1; bus.req_a0 = 32'd0; bus.req_b0 = 32'd1;
        bus.rsp_ready = 2'b01;
        cycle("wrap");
        chk("wrap.rsp_data", 64'(bus.rsp_data), 64'(32'hFFFF_FFFF));
        chk("wrap.rsp_zero", 64'(bus.rsp_zero), 64'(0));
        bus.req_op0 = 4'hF; bus.req_a0 = 32'd2; bus.req_b0 = 32'd3;
        cycle("unk");
        chk("unk.rsp_data", 64'(bus.rsp_data), 64'(5));

        // reset while FULL discards the held result
        #2;
        reset = 1'b1;
        #1;
        chk("rstfull.rsp_valid", 64'(bus.rsp_valid), 64'(0));
        chk("rstfull.req_ready", 64'(bus.req_ready), 64'(0));
        model_reset();
        bus.req_valid = 2'b00;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        cycle("rstfull_idle");
        chk("rstfull.no_stale", 64'(bus.rsp_valid), 64'(0));
        bus.req_valid = 2'b01; bus.req_op0 = 4'd0; bus.req_a0 = 32'd20; bus.req_b0 = 32'd22;
        cycle("rstfull_new");
        chk("rstfull.new_data", 64'(bus.rsp_data), 64'(42));
        bus.req_valid = 2'b00;
        cycle("rstfull_drain");

        // randomized stress against the reference
        do_reset();
        for (int n = 0; n < 10000; n++) begin
            if (!(bus.req_valid[0] && !prev_grant[0])) randomize_requester(0);
            if (!(bus.req_valid[1] && !prev_grant[1])) randomize_requester(1);
            bus.rsp_ready = {($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0)};
            cycle("rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default `REG_FILE_WIDTH (32), operand/result width.
REQ-002 SHALL have parameter OPW, default 4, ALU opcode width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 req_valid[1:0]  input  2  per-requester request valid (index 0 = pipeline, 1 = auxiliary).
REQ-006 req_ready[1:0]  output  2  per-requester accept; handshake when valid && ready.
REQ-007 req_op0, req_op1  input  OPW each  ALU opcode per requester (0 ADD, 1 SUB, others = ADD).
REQ-008 req_a0, req_b0, req_a1, req_b1  input  WIDTH each  operands per requester.
REQ-009 rsp_valid[1:0]  output  2  result valid, one-hot, tagged to the originating requester.
REQ-010 rsp_ready[1:0]  input  2  per-requester result accept.
REQ-011 rsp_data  output  WIDTH  registered ALU result.
REQ-012 rsp_zero  output  1  registered zero flag: 1 iff rsp_data == 0.

Function
REQ-013 SHALL share one combinational ALU between two requesters, issuing at most one operation per cycle.
REQ-014 SHALL hold a one-entry result register with FSM states EMPTY and FULL.
REQ-015 EMPTY: req_ready granted to one valid requester; on handshake, result/zero/tag captured -> FULL next cycle.
REQ-016 FULL: rsp_valid[tag]=1; if rsp_ready[tag]=1 and a new grant occurs same cycle, register reloads, stays FULL (full throughput, 1 op/cycle).
REQ-017 FULL with rsp_ready[tag]=0: req_ready SHALL be 2'b00, register and outputs held stable.
REQ-018 FULL with rsp_ready[tag]=1 and no valid request -> EMPTY, rsp_valid=0 next cycle.
REQ-019 Latency: handshake in cycle N -> rsp_valid in cycle N+1.
REQ-020 Arbitration SHALL be round-robin: a last_grant flop; when both valid, grant goes to the requester not granted last.
REQ-021 Only one requester valid: it SHALL be granted regardless of last_grant (no idle cycle).
REQ-022 req_ready SHALL be one-hot or zero, never 2'b11; rsp_valid likewise.
REQ-023 req_ready SHALL not depend on the non-granted requester's operands/op; it MAY depend combinationally on req_valid and rsp_ready.
REQ-024 Requesters SHALL hold op/operands stable while valid && !ready; arbiter may re-arbitrate each cycle.
REQ-025 ADD/SUB SHALL wrap modulo 2^WIDTH; no carry/overflow output.
REQ-026 Unknown opcode SHALL perform ADD; simulation-only warning permitted.
REQ-027 rsp_data only meaningful while rsp_valid!=0; value held while FULL and not accepted.

Reset
REQ-028 On reset: state EMPTY, rsp_valid=2'b00, rsp_data=0, rsp_zero=0, tag=0, last_grant=1 (requester 0 wins first tie).
REQ-029 Reset asserted mid-operation SHALL discard the pending result; no response delivered after reset.
REQ-030 req_ready SHALL be 2'b00 while reset is asserted.

Structure
REQ-031 Width constant `REG_FILE_WIDTH and opcode values (ADD=0, SUB=1) SHALL come from shared header.vh.
REQ-032 The ALU SHALL be one instantiated sub-module, alu; arbiter holds only FSM, round-robin pointer and result register.
REQ-033 Target size 120-400 lines RTL, no memories, no latches.

Verification
REQ-034 Reset, then req_valid=01, op0=0, a0=5, b0=7, rsp_ready=01 -> next cycle rsp_valid=01, rsp_data=12, rsp_zero=0.
REQ-035 req_valid=11 continuously, rsp_ready=11, op0=SUB a0=b0=9, op1=ADD a1=1 b1=2 -> grants alternate 0,1,0,1; responses 0 (zero=1), 3, 0, 3 every cycle.
REQ-036 Requester 1 result FULL, rsp_ready=00 for 3 cycles with req_valid=11 -> req_ready=00, rsp_data=3 held; rsp_ready=10 -> retired, next grant to requester 0.
REQ-037 op0=SUB a0=0 b0=1 -> rsp_data=32'hFFFF_FFFF, zero=0; op0=4'hF a0=2 b0=3 -> rsp_data=5.
REQ-038 Reset asserted while FULL -> rsp_valid=00 immediately; after release only new requests produce responses.
REQ-039 Random valid/ready stress 10k cycles -> scoreboard matches every result in order per requester, req_ready never 11, no starvation beyond 1 cycle.
